// File: rtl/vbank_array.sv
`default_nettype none
// ============================================================================
// Module      : vbank_array
// Description : Multi-bank, multi-read-port vector memory. NUM_BANKS
//               low-order-interleaved banks, each with one read and one
//               write port. Per-bank round-robin arbitration picks one
//               reader per bank per cycle. Denied readers are held off with
//               a valid/ready handshake. One masked write port is always
//               accepted.
//
// Ports       : clk            - clock, rising edge
//               rst            - synchronous active-high reset
//               i_rreq         - per-port read request valid
//               i_raddr        - per-port global row address (packed)
//               o_rready       - per-port grant (idle ports report ready)
//               o_rvalid       - per-port read data valid, 1 cycle after accept
//               o_rdata        - per-port read row (packed, holds when idle)
//               i_wen          - write enable
//               i_waddr        - write address
//               i_wdata        - write row
//               i_wstrb        - per-element write mask
//               o_conflict_cnt - saturating count of cycles with a denied port
//
// Macro       : VBANK_ARRAY_WR_BYPASS_EN - when defined, a read accepted in the
//               same cycle as a write to the same address returns the new
//               data for strobed elements (write-first per element).
//               Undefined: read-before-write for all elements.
//
// Revision    : 1.0 - initial release
// ============================================================================
module vbank_array #(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_ROWS       = 64,
  parameter int NUM_ELEMENTS   = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int INDEX_WIDTH    = $clog2(NUM_BANKS * NUM_ROWS),
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NUM_READ_PORTS-1:0]                          i_rreq,
  input  logic [NUM_READ_PORTS*INDEX_WIDTH-1:0]              i_raddr,
  output logic [NUM_READ_PORTS-1:0]                          o_rready,
  output logic [NUM_READ_PORTS-1:0]                          o_rvalid,
  output logic [NUM_READ_PORTS*NUM_ELEMENTS*DATA_WIDTH-1:0]  o_rdata,
  input  logic                                               i_wen,
  input  logic [INDEX_WIDTH-1:0]                             i_waddr,
  input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]                 i_wdata,
  input  logic [NUM_ELEMENTS-1:0]                            i_wstrb,
  output logic [CNT_WIDTH-1:0]                               o_conflict_cnt
);

  localparam int c_bank_w   = $clog2(NUM_BANKS);
  localparam int c_row_w    = INDEX_WIDTH - c_bank_w;
  localparam int c_row_bits = NUM_ELEMENTS * DATA_WIDTH;
  localparam int c_rr_w     = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;

  // Port index visited at step k of a round-robin scan starting at base.
  function automatic int rr_idx(input logic [c_rr_w-1:0] base, input int k);
    return (int'(base) + k) % NUM_READ_PORTS;
  endfunction

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [c_bank_w-1:0] w_port_bank [NUM_READ_PORTS];
  logic [c_row_w-1:0]  w_port_row  [NUM_READ_PORTS];

  generate
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port_dec
      assign w_port_bank[p] = i_raddr[p*INDEX_WIDTH +: c_bank_w];
      assign w_port_row[p]  = i_raddr[p*INDEX_WIDTH + c_bank_w +: c_row_w];
    end
  endgenerate

  logic [c_bank_w-1:0] w_wr_bank;
  logic [c_row_w-1:0]  w_wr_row;
  logic                w_wr_fire;

  assign w_wr_bank = i_waddr[c_bank_w-1:0];
  assign w_wr_row  = i_waddr[INDEX_WIDTH-1:c_bank_w];
  // Writes presented during reset are discarded.
  assign w_wr_fire = i_wen & ~rst;

  // --------------------------------------------------------------------------
  // Per-bank round-robin arbitration
  // --------------------------------------------------------------------------
  logic [c_rr_w-1:0]         r_rr       [NUM_BANKS];
  logic [NUM_BANKS-1:0]      w_bank_hit;
  logic [c_rr_w-1:0]         w_bank_win [NUM_BANKS];
  logic [c_row_w-1:0]        w_bank_row [NUM_BANKS];
  logic [NUM_READ_PORTS-1:0] w_grant;
  logic [NUM_READ_PORTS-1:0] w_accept;
  logic                      w_any_denied;

  // Each bank scans ports starting at its pointer; the first requester
  // targeting the bank wins and its row drives that bank's read port.
  always_comb begin
    w_grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_hit[b] = 1'b0;
      w_bank_win[b] = '0;
      w_bank_row[b] = '0;
      for (int k = 0; k < NUM_READ_PORTS; k++) begin
        if (!w_bank_hit[b] && i_rreq[rr_idx(r_rr[b], k)] &&
            (w_port_bank[rr_idx(r_rr[b], k)] == c_bank_w'(b))) begin
          w_bank_hit[b]                 = 1'b1;
          w_bank_win[b]                 = c_rr_w'(rr_idx(r_rr[b], k));
          w_bank_row[b]                 = w_port_row[rr_idx(r_rr[b], k)];
          w_grant[rr_idx(r_rr[b], k)]   = 1'b1;
        end
      end
    end
  end

  // Idle ports report ready; everything is held off while in reset.
  assign o_rready     = rst ? '0 : (~i_rreq | w_grant);
  assign w_accept     = i_rreq & o_rready;
  assign w_any_denied = |(i_rreq & ~o_rready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_rr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bank_hit[b]) begin
          r_rr[b] <= c_rr_w'((int'(w_bank_win[b]) + 1) % NUM_READ_PORTS);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bank storage: one write port, one read port per bank
  // --------------------------------------------------------------------------
  logic [c_row_bits-1:0] w_bank_rd [NUM_BANKS];

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [c_row_bits-1:0] r_mem [NUM_ROWS];
      logic [c_row_bits-1:0] w_mem_rd;
      logic [c_row_bits-1:0] w_rd;

      // Contents are intentionally not reset.
      always_ff @(posedge clk) begin
        if (w_wr_fire && (w_wr_bank == c_bank_w'(b))) begin
          for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (i_wstrb[i]) begin
              r_mem[w_wr_row][i*DATA_WIDTH +: DATA_WIDTH] <=
                i_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end

      assign w_mem_rd = r_mem[w_bank_row[b]];

`ifdef VBANK_ARRAY_WR_BYPASS_EN
      // Write-first per element when the winning read hits the row being
      // written this cycle.
      always_comb begin
        w_rd = w_mem_rd;
        if (w_wr_fire && (w_wr_bank == c_bank_w'(b)) &&
            (w_wr_row == w_bank_row[b])) begin
          for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (i_wstrb[i]) begin
              w_rd[i*DATA_WIDTH +: DATA_WIDTH] = i_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
`else
      // Read-before-write: the array value sampled at the edge is the old row.
      assign w_rd = w_mem_rd;
`endif

      assign w_bank_rd[b] = w_rd;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read response registers
  // --------------------------------------------------------------------------
  logic [NUM_READ_PORTS-1:0] r_rvalid;
  logic [c_row_bits-1:0]     r_rdata [NUM_READ_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= '0;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        r_rdata[p] <= '0;
      end
    end else begin
      r_rvalid <= w_accept;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        // Arbitration ensures the bank's read port serves exactly this port.
        if (w_accept[p]) begin
          r_rdata[p] <= w_bank_rd[w_port_bank[p]];
        end
      end
    end
  end

  assign o_rvalid = r_rvalid;

  generate
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port_out
      assign o_rdata[p*c_row_bits +: c_row_bits] = r_rdata[p];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Saturating conflict counter
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_any_denied && (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vbank_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_vbank_array
// Description : Directed self-checking bench for vbank_array (2 read ports,
//               4 banks, 4-bit conflict counter). Covers reset, masked write,
//               parallel reads, round-robin conflicts, same-cycle read/write,
//               empty-strobe writes and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vbank_array;

  localparam int NE = 32;
  localparam int DW = 16;
  localparam int RB = NE * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rreq;
  logic [15:0]     raddr;
  logic [1:0]      rready;
  logic [1:0]      rvalid;
  logic [2*RB-1:0] rdata;
  logic            wen;
  logic [7:0]      waddr;
  logic [RB-1:0]   wdata;
  logic [NE-1:0]   wstrb;
  logic [3:0]      cnt;

  logic [RB-1:0]   exp_masked;
  logic [RB-1:0]   exp_rw;

  int t_run  = 0;
  int t_fail = 0;

  always #5 clk = ~clk;

  vbank_array #(
    .CNT_WIDTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rreq         (rreq),
    .i_raddr        (raddr),
    .o_rready       (rready),
    .o_rvalid       (rvalid),
    .o_rdata        (rdata),
    .i_wen          (wen),
    .i_waddr        (waddr),
    .i_wdata        (wdata),
    .i_wstrb        (wstrb),
    .o_conflict_cnt (cnt)
  );

  task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
    t_run++;
    assert (obs === exp) else begin
      t_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB-1:0] fill(input logic [15:0] v);
    return {NE{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_full(input logic [7:0] a, input logic [15:0] v);
    wen   = 1'b1;
    waddr = a;
    wdata = fill(v);
    wstrb = '1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NE; i++) begin
      exp_masked[i*DW +: DW] = (i < 16) ? 16'(i) : 16'hAAAA;
    end
`ifdef VBANK_ARRAY_WR_BYPASS_EN
    exp_rw = fill(16'h2222);
`else
    exp_rw = fill(16'h1111);
`endif

    // Reset held for two cycles with both ports requesting.
    rst = 1'b1; rreq = 2'b11; raddr = {8'h05, 8'h04};
    wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    tick();
    chk("rst1_rready", rready, 2'b00);
    chk("rst1_rvalid", rvalid, 2'b00);
    chk("rst1_rdata",  rdata[RB-1:0] | rdata[2*RB-1:RB], '0);
    chk("rst1_cnt",    cnt, 4'h0);
    tick();
    chk("rst2_rready", rready, 2'b00);
    chk("rst2_rvalid", rvalid, 2'b00);
    chk("rst2_cnt",    cnt, 4'h0);

    // First request after release.
    rst = 1'b0; rreq = 2'b01; raddr = {8'h00, 8'h05};
    #1;
    chk("first_rready", rready, 2'b11);
    tick();
    chk("first_rvalid", rvalid, 2'b01);
    rreq = 2'b00;

    // Background rows, then a masked write over 0x05.
    wr_full(8'h05, 16'hAAAA);
    for (int i = 0; i < NE; i++) wdata[i*DW +: DW] = 16'(i);
    wstrb = 32'h0000FFFF;
    tick();
    wr_full(8'h04, 16'h0404);
    wr_full(8'h08, 16'h0808);
    wr_full(8'h0C, 16'h0C0C);
    wr_full(8'h10, 16'h1111);
    wen = 1'b0;

    // Masked row readback on port 0.
    rreq = 2'b01; raddr = {8'h00, 8'h05};
    #1;
    chk("mask_rready", rready, 2'b11);
    chk("mask_pre_rvalid", rvalid, 2'b00);
    tick();
    chk("mask_rvalid", rvalid, 2'b01);
    chk("mask_rdata0", rdata[RB-1:0], exp_masked);
    rreq = 2'b00;
    tick();
    chk("idle_rvalid", rvalid, 2'b00);
    chk("idle_hold0", rdata[RB-1:0], exp_masked);

    // Parallel reads to different banks.
    rreq = 2'b11; raddr = {8'h05, 8'h04};
    #1;
    chk("par_rready", rready, 2'b11);
    tick();
    chk("par_rvalid", rvalid, 2'b11);
    chk("par_rdata0", rdata[RB-1:0], fill(16'h0404));
    chk("par_rdata1", rdata[2*RB-1:RB], exp_masked);
    chk("par_cnt", cnt, 4'h0);

    // Reset again with a write pending: write must be ignored, rr cleared.
    rst = 1'b1; wen = 1'b1; waddr = 8'h10; wdata = fill(16'hDEAD); wstrb = '1;
    #1;
    chk("rst3_rready", rready, 2'b00);
    tick();
    rst = 1'b0; wen = 1'b0;
    chk("rst3_rvalid", rvalid, 2'b00);
    chk("rst3_rdata0", rdata[RB-1:0], '0);

    // Bank-0 conflict held for three cycles: port0, port1, port0.
    rreq = 2'b11; raddr = {8'h0C, 8'h08};
    #1;
    chk("cf1_rready", rready, 2'b01);
    tick();
    chk("cf1_rvalid", rvalid, 2'b01);
    chk("cf1_rdata0", rdata[RB-1:0], fill(16'h0808));
    chk("cf1_cnt", cnt, 4'h1);
    #1;
    chk("cf2_rready", rready, 2'b10);
    tick();
    chk("cf2_rvalid", rvalid, 2'b10);
    chk("cf2_rdata1", rdata[2*RB-1:RB], fill(16'h0C0C));
    chk("cf2_hold0", rdata[RB-1:0], fill(16'h0808));
    chk("cf2_cnt", cnt, 4'h2);
    #1;
    chk("cf3_rready", rready, 2'b01);
    tick();
    chk("cf3_rvalid", rvalid, 2'b01);
    chk("cf3_cnt", cnt, 4'h3);

    // Same-cycle read and full write of 0x10.
    rreq = 2'b01; raddr = {8'h00, 8'h10};
    wen = 1'b1; waddr = 8'h10; wdata = fill(16'h2222); wstrb = '1;
    #1;
    chk("rw_rready", rready, 2'b11);
    tick();
    chk("rw_rdata0", rdata[RB-1:0], exp_rw);
    chk("rw_cnt", cnt, 4'h3);

    // Empty-strobe write is a no-op.
    wdata = '0; wstrb = '0;
    tick();
    chk("nostrb_same", rdata[RB-1:0], fill(16'h2222));
    wen = 1'b0;
    tick();
    chk("nostrb_after", rdata[RB-1:0], fill(16'h2222));

    // Counter saturation.
    rst = 1'b1; rreq = 2'b00;
    tick();
    rst = 1'b0;
    chk("sat_start", cnt, 4'h0);
    rreq = 2'b11; raddr = {8'h0C, 8'h08};
    repeat (10) tick();
    chk("sat_10", cnt, 4'hA);
    repeat (10) tick();
    chk("sat_20", cnt, 4'hF);
    repeat (5) tick();
    chk("sat_hold", cnt, 4'hF);

    rreq = 2'b00;
    #1;
    chk("idle_ready", rready, 2'b11);

    $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
    $finish;
  end

endmodule
`default_nettype wire
